// File: rtl/sound_player.sv
// sound_player: turns game sound requests into square-wave note sequences on a buzzer pin.
// Ports: clk, rst (sync, active-high), sound_code/play_sound in; buzzer, amp_en, busy, cur_code out.
module sound_player #(
  parameter int CLK_FREQ = 100_000_000,
  parameter int NOTE_MS  = 100,
  parameter int GAP_MS   = 200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] sound_code,
  input  logic       play_sound,
  output logic       buzzer,
  output logic       amp_en,
  output logic       busy,
  output logic [2:0] cur_code
);

  localparam int NOTE_CYCLES = CLK_FREQ / 1000 * NOTE_MS;
  localparam int GAP_CYCLES  = CLK_FREQ / 1000 * GAP_MS;
  localparam int NW = $clog2(NOTE_CYCLES + 1);
  localparam int GW = $clog2(GAP_CYCLES + 1);
  // Wide enough for the lowest note at the default 100 MHz clock.
  localparam int HW = $clog2(100_000_000 / (2 * 523) + 1);

  // Terminal counts (half period minus one) per note.
  localparam logic [HW-1:0] HL_C5 = HW'(CLK_FREQ / (2 * 523) - 1);
  localparam logic [HW-1:0] HL_E5 = HW'(CLK_FREQ / (2 * 659) - 1);
  localparam logic [HW-1:0] HL_G5 = HW'(CLK_FREQ / (2 * 784) - 1);
  localparam logic [HW-1:0] HL_C6 = HW'(CLK_FREQ / (2 * 1047) - 1);

  localparam logic [NW-1:0] NOTE_LAST = NW'(NOTE_CYCLES - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    HOLD = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [2:0]    code_q, code_d;
  logic [1:0]    idx_q, idx_d;
  logic [NW-1:0] note_q, note_d;
  logic [HW-1:0] half_q, half_d;
  logic [GW-1:0] gap_q, gap_d;
  logic          buzz_q, buzz_d;

  logic [HW-1:0] half_lim;
  logic [1:0]    last_idx;
  logic          trig_ok;
  logic          start;

  // Note table: half-period limit and last note index of the active code.
  always_comb begin
    half_lim = HL_C6;
    last_idx = 2'd0;
    case (code_q)
      3'd2: begin
        last_idx = 2'd1;
        half_lim = (idx_q == 2'd0) ? HL_E5 : HL_G5;
      end
      3'd3: begin
        last_idx = 2'd3;
        case (idx_q)
          2'd0:    half_lim = HL_C5;
          2'd1:    half_lim = HL_E5;
          2'd2:    half_lim = HL_G5;
          default: half_lim = HL_C6;
        endcase
      end
      default: begin
        half_lim = HL_C6;
        last_idx = 2'd0;
      end
    endcase
  end

  // code_q is 0 in IDLE, so one compare covers both a fresh start and
  // strictly-higher-priority preemption (priority equals the code value).
  assign trig_ok = play_sound && (sound_code >= 3'd1) && (sound_code <= 3'd3);
  assign start   = trig_ok && (sound_code > code_q);

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    idx_d   = idx_q;
    note_d  = note_q;
    half_d  = half_q;
    gap_d   = gap_q;
    buzz_d  = buzz_q;
    unique case (state_q)
      IDLE: begin
        buzz_d = 1'b0;
      end
      PLAY: begin
        if (half_q == half_lim) begin
          half_d = '0;
          buzz_d = ~buzz_q;
        end else begin
          half_d = half_q + 1'b1;
        end
        if (note_q == NOTE_LAST) begin
          note_d = '0;
          half_d = '0;
          if (idx_q == last_idx) begin
            state_d = HOLD;
            buzz_d  = 1'b0;
            gap_d   = '0;
          end else begin
            idx_d  = idx_q + 1'b1;
            buzz_d = 1'b1;
          end
        end else begin
          note_d = note_q + 1'b1;
        end
      end
      HOLD: begin
        buzz_d = 1'b0;
        if (gap_q == GAP_LAST) begin
          state_d = IDLE;
          code_d  = 3'd0;
          gap_d   = '0;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        code_d  = 3'd0;
        buzz_d  = 1'b0;
      end
    endcase
    // A new or preempting request overrides boundaries and gap expiry.
    if (start) begin
      state_d = PLAY;
      code_d  = sound_code;
      idx_d   = 2'd0;
      note_d  = '0;
      half_d  = '0;
      gap_d   = '0;
      buzz_d  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      code_q  <= 3'd0;
      idx_q   <= 2'd0;
      note_q  <= '0;
      half_q  <= '0;
      gap_q   <= '0;
      buzz_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      idx_q   <= idx_d;
      note_q  <= note_d;
      half_q  <= half_d;
      gap_q   <= gap_d;
      buzz_q  <= buzz_d;
    end
  end

  assign buzzer   = buzz_q;
  assign amp_en   = (state_q == PLAY);
  assign busy     = (state_q != IDLE);
  assign cur_code = code_q;

endmodule

// File: tb/tb_sound_player.sv
// tb_sound_player: scoreboard bench for sound_player at reduced clock settings.
// Expected output vectors are queued with their due cycle and checked on the falling edge.
module tb_sound_player;

  logic       clk;
  logic       rst;
  logic [2:0] sound_code;
  logic       play_sound;
  logic       buzzer;
  logic       amp_en;
  logic       busy;
  logic [2:0] cur_code;

  sound_player #(
    .CLK_FREQ(100_000),
    .NOTE_MS (10),
    .GAP_MS  (5)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .sound_code(sound_code),
    .play_sound(play_sound),
    .buzzer    (buzzer),
    .amp_en    (amp_en),
    .busy      (busy),
    .cur_code  (cur_code)
  );

  localparam int NOTE = 1000;
  localparam int GAP  = 500;
  localparam int H_C6 = 47;
  localparam int H_E5 = 75;
  localparam int H_G5 = 63;
  localparam int H_C5 = 95;

  typedef struct {
    string      tag;
    int         at;
    logic [5:0] exp;
  } sb_item_t;

  sb_item_t sb[$];
  int cyc = 0;
  int amp_cnt = 0;
  int n_cmp = 0;
  int n_err = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(negedge clk) if (amp_en) amp_cnt++;

  function automatic void sb_push(string tag, int at, logic [5:0] exp);
    int i;
    sb_item_t it;
    it.tag = tag;
    it.at  = at;
    it.exp = exp;
    i = sb.size();
    while (i > 0 && sb[i-1].at > at) i--;
    sb.insert(i, it);
  endfunction

  // Sample points inside one note; buzzer level from elapsed half periods.
  function automatic void push_note(string tag, int st, int h,
                                    logic [2:0] c, int len);
    int ks[8];
    logic b;
    ks[0] = 0;
    ks[1] = 1;
    ks[2] = h - 1;
    ks[3] = h;
    ks[4] = 2 * h - 1;
    ks[5] = 2 * h;
    ks[6] = 3 * h;
    ks[7] = len - 1;
    for (int i = 0; i < 8; i++) begin
      if (ks[i] < len) begin
        b = ((ks[i] / h) % 2 == 0);
        sb_push(tag, st + ks[i], {b, 1'b1, 1'b1, c});
      end
    end
  endfunction

  function automatic void push_gap(string tag, int st, logic [2:0] c);
    sb_push(tag, st, {3'b001, c});
    sb_push(tag, st + GAP - 1, {3'b001, c});
    sb_push({tag, "_idle"}, st + GAP, 6'b0);
  endfunction

  function automatic void push_c3(string tag, int st, int len);
    int hs[4];
    hs[0] = H_C5;
    hs[1] = H_E5;
    hs[2] = H_G5;
    hs[3] = H_C6;
    for (int i = 0; i < 4; i++) begin
      if (i * NOTE < len) begin
        push_note(tag, st + i * NOTE, hs[i], 3'd3,
                  (len - i * NOTE < NOTE) ? len - i * NOTE : NOTE);
      end
    end
  endfunction

  always @(negedge clk) begin
    sb_item_t e;
    while (sb.size() > 0 && sb[0].at <= cyc) begin
      e = sb.pop_front();
      n_cmp++;
      assert (e.at == cyc) else begin
        n_err++;
        $error("FAIL %s_late obs=%0d exp=%0d", e.tag, cyc, e.at);
      end
      assert ({buzzer, amp_en, busy, cur_code} === e.exp) else begin
        n_err++;
        $error("FAIL %s cyc=%0d obs=%b exp=%b", e.tag, cyc,
               {buzzer, amp_en, busy, cur_code}, e.exp);
      end
    end
  end

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic drain(input string tag, input int budget);
    int b;
    b = budget;
    while (sb.size() > 0 && b > 0) begin
      @(negedge clk);
      b--;
    end
    n_cmp++;
    assert (sb.size() == 0) else begin
      n_err++;
      $error("FAIL %s_drain obs=%0d exp=0", tag, sb.size());
      sb.delete();
    end
  endtask

  task automatic pulse(input logic [2:0] c, output int n);
    @(negedge clk);
    sound_code = c;
    play_sound = 1'b1;
    n = cyc + 1;
    @(negedge clk);
    play_sound = 1'b0;
  endtask

  initial begin
    int n;
    int m;
    int a0;
    rst = 1'b1;
    sound_code = 3'd0;
    play_sound = 1'b0;

    // reset state
    sb_push("rst0", 2, 6'b0);
    sb_push("rst1", 3, 6'b0);
    wait_cyc(4);
    rst = 1'b0;
    drain("rst", 20);

    // code 1: single C6 note, gap, idle
    pulse(3'd1, n);
    push_note("c1_n0", n, H_C6, 3'd1, NOTE);
    push_gap("c1_gap", n + NOTE, 3'd1);
    sb_push("c1_after", n + NOTE + GAP + 10, 6'b0);
    drain("c1", 2000);

    // code 2: E5 then G5, amp_en exactly 2000 cycles
    wait_cyc(cyc + 5);
    a0 = amp_cnt;
    pulse(3'd2, n);
    push_note("c2_n0", n, H_E5, 3'd2, NOTE);
    push_note("c2_n1", n + NOTE, H_G5, 3'd2, NOTE);
    push_gap("c2_gap", n + 2 * NOTE, 3'd2);
    drain("c2", 3000);
    n_cmp++;
    assert (amp_cnt - a0 == 2 * NOTE) else begin
      n_err++;
      $error("FAIL c2_amp_cycles obs=%0d exp=%0d", amp_cnt - a0, 2 * NOTE);
    end

    // code 3 held: melody, gap, one idle cycle, melody again
    @(negedge clk);
    sound_code = 3'd3;
    play_sound = 1'b1;
    n = cyc + 1;
    m = n + 4 * NOTE + GAP + 1;
    push_c3("c3a", n, 4 * NOTE);
    push_gap("c3a_gap", n + 4 * NOTE, 3'd3);
    push_c3("c3b", m, 4 * NOTE);
    push_gap("c3b_gap", m + 4 * NOTE, 3'd3);
    sb_push("c3_stop", m + 4 * NOTE + GAP + 50, 6'b0);
    wait_cyc(n + 5999);
    play_sound = 1'b0;
    drain("c3", 5000);

    // code 1 preempted by code 3 at cycle 300; code 2 then ignored
    pulse(3'd1, n);
    push_note("pre_c1", n, H_C6, 3'd1, 300);
    wait_cyc(n + 298);
    pulse(3'd3, m);
    push_c3("pre_c3", m, 4 * NOTE);
    push_gap("pre_gap", m + 4 * NOTE, 3'd3);
    wait_cyc(m + 1498);
    pulse(3'd2, n);
    sb_push("pre_ign2", n, {1'b1, 1'b1, 1'b1, 3'd3});
    sb_push("pre_ign2b", n + 1, {1'b1, 1'b1, 1'b1, 3'd3});
    drain("pre", 5000);

    // invalid codes while idle
    pulse(3'd0, n);
    sb_push("inv0", n, 6'b0);
    sb_push("inv0b", n + 1, 6'b0);
    pulse(3'd5, n);
    sb_push("inv5", n, 6'b0);
    sb_push("inv5b", n + 1, 6'b0);
    drain("inv", 20);

    // reset in the middle of a code 3 melody
    pulse(3'd3, n);
    push_c3("mid_c3", n, 1500);
    wait_cyc(n + 1498);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sb_push("mid_rst", n + 1500, 6'b0);
    sb_push("mid_rst1", n + 1501, 6'b0);
    sb_push("mid_rst2", n + 1510, 6'b0);
    drain("mid", 100);

    // fresh start after abort
    pulse(3'd1, n);
    push_note("post_c1", n, H_C6, 3'd1, 100);
    drain("post", 200);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
